// File: rtl/dcache1_wb_queue.sv
// Victim/writeback address queue between the dcache1 tag ways and the L2 request port.
// Optional same-cycle bypass of an empty queue is enabled by defining DCACHE1_WBQ_BYPASS_EN.
module dcache1_wb_queue #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 37,
    parameter int PTR_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic                  wb_valid,
    output logic                  wbq_full,
    output logic [PTR_WIDTH:0]    wbq_count,
    input  logic [ADDR_WIDTH-1:0] chk_addr,
    output logic                  chk_hit,
    output logic                  l2_req_valid,
    output logic [ADDR_WIDTH-1:0] l2_req_addr,
    input  logic                  l2_req_ready,
    output logic                  wbq_ovf
);

    logic [DEPTH-1:0]      vld_r;
    logic [ADDR_WIDTH-1:0] addr_r [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_r;
    logic [PTR_WIDTH-1:0]  rd_ptr_r;
    logic [PTR_WIDTH:0]    count_r;
    logic                  full_r;
    logic                  ovf_r;

    logic [DEPTH-1:0]      wb_match_s;
    logic [DEPTH-1:0]      chk_match_s;
    logic [DEPTH-1:0]      pop_mask_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  coalesce_s;
    logic                  bypass_show_s;
    logic                  bypass_take_s;
    logic                  alloc_s;
    logic                  drop_s;
    logic [PTR_WIDTH:0]    count_next_s;

    // Address comparators against every valid entry for coalescing and hazard lookup.
    always_comb begin
        wb_match_s  = '0;
        chk_match_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wb_match_s[i]  = vld_r[i] && (addr_r[i] == wb_addr);
            chk_match_s[i] = vld_r[i] && (addr_r[i] == chk_addr);
        end
    end

    // Push/pop qualification, coalescing and allocation decisions.
    always_comb begin
        push_s = wb_en & wb_valid;
        pop_s  = vld_r[rd_ptr_r] & l2_req_ready;
        if (pop_s) begin
            pop_mask_s = {{(DEPTH-1){1'b0}}, 1'b1} << rd_ptr_r;
        end else begin
            pop_mask_s = '0;
        end
        // A duplicate of the head leaving this edge must be re-issued, so it does not coalesce.
        coalesce_s = |(wb_match_s & ~pop_mask_s);
`ifdef DCACHE1_WBQ_BYPASS_EN
        bypass_show_s = push_s & (count_r == '0);
`else
        bypass_show_s = 1'b0;
`endif
        bypass_take_s = bypass_show_s & l2_req_ready;
        alloc_s       = push_s & ~coalesce_s & ~full_r & ~bypass_take_s;
        drop_s        = push_s & ~coalesce_s & full_r;
        count_next_s  = count_r + (PTR_WIDTH+1)'(alloc_s) - (PTR_WIDTH+1)'(pop_s);
    end

    // Request port: head of storage, or the incoming victim when bypassing an empty queue.
    always_comb begin
        l2_req_valid = vld_r[rd_ptr_r];
        l2_req_addr  = '0;
        if (bypass_show_s) begin
            l2_req_valid = 1'b1;
            l2_req_addr  = wb_addr;
        end else if (vld_r[rd_ptr_r]) begin
            l2_req_addr = addr_r[rd_ptr_r];
        end else begin
            l2_req_addr = '0;
        end
    end

    // Entry storage, pointers and status; the queue updates on the falling clock edge.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            vld_r    <= '0;
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            full_r   <= 1'b0;
            ovf_r    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_r[i] <= '0;
            end
        end else begin
            if (pop_s) begin
                vld_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r        <= rd_ptr_r + PTR_WIDTH'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            if (alloc_s) begin
                vld_r[wr_ptr_r]  <= 1'b1;
                addr_r[wr_ptr_r] <= wb_addr;
                wr_ptr_r         <= wr_ptr_r + PTR_WIDTH'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            count_r <= count_next_s;
            full_r  <= (count_next_s == (PTR_WIDTH+1)'(DEPTH));
            ovf_r   <= ovf_r | drop_s;
        end
    end

    assign wbq_full  = full_r;
    assign wbq_count = count_r;
    assign wbq_ovf   = ovf_r;
    assign chk_hit   = |chk_match_s;

endmodule

// File: tb/tb_dcache1_wb_queue.sv
// Self-checking bench for dcache1_wb_queue: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_dcache1_wb_queue;
    localparam int DEPTH = 8;
    localparam int AW    = 37;
    localparam int PW    = 3;
`ifdef DCACHE1_WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          wb_en, wb_valid, l2_req_ready;
    logic [AW-1:0] wb_addr, chk_addr;
    logic          wbq_full, chk_hit, l2_req_valid, wbq_ovf;
    logic [PW:0]   wbq_count;
    logic [AW-1:0] l2_req_addr;

    logic [AW-1:0] q[$];
    bit            ovf_m;
    int            checks = 0;
    int            errors = 0;

    dcache1_wb_queue #(.DEPTH(DEPTH), .ADDR_WIDTH(AW), .PTR_WIDTH(PW)) dut (
        .clk(clk), .rst(rst), .wb_en(wb_en), .wb_addr(wb_addr), .wb_valid(wb_valid),
        .wbq_full(wbq_full), .wbq_count(wbq_count), .chk_addr(chk_addr), .chk_hit(chk_hit),
        .l2_req_valid(l2_req_valid), .l2_req_addr(l2_req_addr), .l2_req_ready(l2_req_ready),
        .wbq_ovf(wbq_ovf)
    );

    always #5 clk = ~clk;

    function automatic bit byp_now();
        return BYP && wb_en && wb_valid && (q.size() == 0);
    endfunction

    function automatic logic exp_valid();
        return (q.size() > 0) || byp_now();
    endfunction

    function automatic logic [AW-1:0] exp_addr();
        if (q.size() > 0) return q[0];
        if (byp_now()) return wb_addr;
        return '0;
    endfunction

    function automatic logic exp_hit();
        foreach (q[i]) if (q[i] == chk_addr) return 1'b1;
        return 1'b0;
    endfunction

    // Inputs change just after the rising edge, well away from the falling update edge.
    task automatic drive(input logic en, input logic vld, input logic [AW-1:0] a,
                         input logic rdy, input logic [AW-1:0] c);
        @(posedge clk);
        wb_en = en; wb_valid = vld; wb_addr = a; l2_req_ready = rdy; chk_addr = c;
        #1;
    endtask

    // Reference model: apply one falling edge's worth of queue rules.
    task automatic commit();
        bit push, pop, match;
        int n;
        @(negedge clk);
        push  = wb_en && wb_valid;
        n     = q.size();
        pop   = (n > 0) && l2_req_ready;
        match = 1'b0;
        for (int i = (pop ? 1 : 0); i < n; i++) if (q[i] == wb_addr) match = 1'b1;
        if (push) begin
            if (byp_now() && l2_req_ready) begin
            end else if (match) begin
            end else if (n == DEPTH) ovf_m = 1'b1;
            else q.push_back(wb_addr);
        end
        if (pop) void'(q.pop_front());
    endtask

    task automatic do_reset();
        wb_en = 1'b0; wb_valid = 1'b0; wb_addr = '0; l2_req_ready = 1'b0; chk_addr = '0;
        rst = 1'b0;
        q.delete(); ovf_m = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        checks++; if (wbq_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", wbq_count); end
        checks++; if (l2_req_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", l2_req_valid); end
        checks++; if (l2_req_addr !== '0) begin errors++; $display("FAIL reset_addr got %h exp 0", l2_req_addr); end
        checks++; if (wbq_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", wbq_full); end
        checks++; if (wbq_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", wbq_ovf); end
        commit();
    endtask

    task automatic test_fifo_order();
        logic [AW-1:0] exp_seq [3];
        exp_seq[0] = 37'h0_1000_0001; exp_seq[1] = 37'h0_2000_0001; exp_seq[2] = 37'h0_3000_0001;
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b1, exp_seq[i], 1'b0, '0); commit(); end
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        checks++; if (wbq_count !== 4'd3) begin errors++; $display("FAIL fifo_count3 got %0d exp 3", wbq_count); end
        commit();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, '0, 1'b1, '0);
            checks++; if (l2_req_valid !== 1'b1 || l2_req_addr !== exp_seq[i]) begin
                errors++; $display("FAIL fifo_pop%0d got %b/%h exp 1/%h", i, l2_req_valid, l2_req_addr, exp_seq[i]); end
            commit();
        end
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        checks++; if (wbq_count !== 4'd0 || l2_req_valid !== 1'b0) begin
            errors++; $display("FAIL fifo_empty got %0d/%b exp 0/0", wbq_count, l2_req_valid); end
        commit();
    endtask

    task automatic test_coalesce();
        logic [AW-1:0] a;
        a = 37'h0_1000_0001;
        do_reset();
        drive(1'b1, 1'b1, a, 1'b0, '0); commit();
        drive(1'b1, 1'b1, a, 1'b0, '0); commit();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        checks++; if (wbq_count !== 4'd1) begin errors++; $display("FAIL coalesce_dup got %0d exp 1", wbq_count); end
        commit();
        drive(1'b1, 1'b1, a, 1'b1, '0); commit();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        checks++; if (wbq_count !== 4'd1 || l2_req_addr !== a) begin
            errors++; $display("FAIL coalesce_reissue got %0d/%h exp 1/%h", wbq_count, l2_req_addr, a); end
        commit();
    endtask

    task automatic test_full_overflow();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin drive(1'b1, 1'b1, AW'(37'h0_0500_0000 + i), 1'b0, '0); commit(); end
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        checks++; if (wbq_full !== 1'b1 || wbq_count !== 4'd8) begin
            errors++; $display("FAIL full_flag got %b/%0d exp 1/8", wbq_full, wbq_count); end
        commit();
        drive(1'b1, 1'b1, 37'h0_0900_0000, 1'b1, 37'h0_0900_0000); commit();
        drive(1'b0, 1'b0, '0, 1'b0, 37'h0_0900_0000);
        checks++; if (wbq_count !== 4'd7 || wbq_ovf !== 1'b1 || chk_hit !== 1'b0) begin
            errors++; $display("FAIL full_drop got %0d/%b/%b exp 7/1/0", wbq_count, wbq_ovf, chk_hit); end
        commit();
    endtask

    task automatic test_hazard();
        do_reset();
        drive(1'b1, 1'b1, 37'h0_1000_0001, 1'b0, '0); commit();
        drive(1'b0, 1'b0, '0, 1'b0, 37'h0_1000_0001);
        checks++; if (chk_hit !== 1'b1) begin errors++; $display("FAIL hazard_hit got %b exp 1", chk_hit); end
        chk_addr = 37'h0_1000_0000; #1;
        checks++; if (chk_hit !== 1'b0) begin errors++; $display("FAIL hazard_bit0 got %b exp 0", chk_hit); end
        commit();
    endtask

    task automatic test_bypass();
        do_reset();
        drive(1'b1, 1'b1, 37'h0_4000_0001, 1'b1, '0);
        checks++; if (l2_req_valid !== BYP) begin errors++; $display("FAIL bypass_same got %b exp %b", l2_req_valid, BYP); end
        commit();
        drive(1'b0, 1'b0, '0, 1'b0, '0);
        checks++; if (wbq_count !== (BYP ? 4'd0 : 4'd1) || l2_req_valid !== ~BYP) begin
            errors++; $display("FAIL bypass_after got %0d/%b exp %0d/%b", wbq_count, l2_req_valid, BYP ? 0 : 1, ~BYP); end
        commit();
    endtask

    task automatic test_random();
        logic [AW-1:0] pool [6];
        for (int i = 0; i < 6; i++) pool[i] = AW'(37'h0_7000_0000 + (i >> 1) * 37'h100 + (i & 1));
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), pool[$urandom_range(0, 5)],
                  1'($urandom_range(0, 2) == 0), pool[$urandom_range(0, 5)]);
            checks++; if (l2_req_valid !== exp_valid() || l2_req_addr !== exp_addr()) begin
                errors++; $display("FAIL rand_req c%0d got %b/%h exp %b/%h", c, l2_req_valid, l2_req_addr, exp_valid(), exp_addr()); end
            checks++; if (wbq_count !== (PW+1)'(q.size()) || wbq_full !== (q.size() == DEPTH)) begin
                errors++; $display("FAIL rand_count c%0d got %0d/%b exp %0d", c, wbq_count, wbq_full, q.size()); end
            checks++; if (chk_hit !== exp_hit() || wbq_ovf !== ovf_m) begin
                errors++; $display("FAIL rand_hit_ovf c%0d got %b/%b exp %b/%b", c, chk_hit, wbq_ovf, exp_hit(), ovf_m); end
            commit();
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        for (int i = 0; i < 3; i++) begin drive(1'b1, 1'b1, AW'(37'h0_0600_0001 + i * 2), 1'b0, '0); commit(); end
        drive(1'b0, 1'b0, '0, 1'b0, 37'h0_0600_0001);
        checks++; if (wbq_count !== 4'd3 || chk_hit !== 1'b1) begin
            errors++; $display("FAIL midrst_pre got %0d/%b exp 3/1", wbq_count, chk_hit); end
        rst = 1'b0; #1;
        checks++; if (wbq_count !== 4'd0 || l2_req_valid !== 1'b0 || chk_hit !== 1'b0) begin
            errors++; $display("FAIL midrst_post got %0d/%b/%b exp 0/0/0", wbq_count, l2_req_valid, chk_hit); end
        q.delete(); ovf_m = 1'b0;
        #3 rst = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fifo_order();
        test_coalesce();
        test_full_overflow();
        test_hazard();
        test_bypass();
        test_random();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
